// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU definitions: widths, opcode constants and opcode check.
// Imported by the command sequencer and by the ALU beside it.
package alu_cmd_sequencer_pkg;

  localparam int ALU_NB_DATA     = 8;
  localparam int ALU_NB_OP       = 6;
  localparam int ALU_NB_DATA_OUT = 9;

  localparam logic [ALU_NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [ALU_NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [ALU_NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [ALU_NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [ALU_NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [ALU_NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [ALU_NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [ALU_NB_OP-1:0] OP_NOR = 6'b100111;

  function automatic logic op_is_valid(
    input logic [ALU_NB_OP-1:0] op
  );
    return op inside {
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR
    };
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the sequencer's byte, ALU and transmitter signals.
// master drives received bytes and responses; slave is the sequencer.
interface alu_cmd_sequencer_if
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int NB_DATA     = ALU_NB_DATA,
  parameter int NB_OP       = ALU_NB_OP,
  parameter int NB_DATA_OUT = ALU_NB_DATA_OUT
);
  logic [NB_DATA-1:0]     rx_data;
  logic                   rx_done;
  logic [NB_DATA-1:0]     data_a;
  logic [NB_DATA-1:0]     data_b;
  logic [NB_OP-1:0]       code;
  logic [NB_DATA_OUT-1:0] alu_result;
  logic [NB_DATA-1:0]     tx_data;
  logic                   tx_start;
  logic                   tx_done;
  logic                   error;
  logic                   overrun;

  modport master (
    output rx_data, rx_done,
    output alu_result, tx_done,
    input  data_a, data_b, code,
    input  tx_data, tx_start,
    input  error, overrun
  );

  modport slave (
    input  rx_data, rx_done,
    input  alu_result, tx_done,
    output data_a, data_b, code,
    output tx_data, tx_start,
    output error, overrun
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Collects A, B, opcode bytes, runs the external ALU and sends
// the 9-bit result back as a low byte then a high byte.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int NB_DATA        = ALU_NB_DATA,
  parameter int NB_OP          = ALU_NB_OP,
  parameter int NB_DATA_OUT    = ALU_NB_DATA_OUT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_DATA-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  output logic [NB_DATA-1:0]     o_data_a,
  output logic [NB_DATA-1:0]     o_data_b,
  output logic [NB_OP-1:0]       o_code,
  input  logic [NB_DATA_OUT-1:0] i_alu_result,
  output logic [NB_DATA-1:0]     o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_error,
  output logic                   o_overrun
);

  localparam logic [2:0] GET_A   = 3'd0;
  localparam logic [2:0] GET_B   = 3'd1;
  localparam logic [2:0] GET_OP  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND_LO = 3'd4;
  localparam logic [2:0] WAIT_LO = 3'd5;
  localparam logic [2:0] SEND_HI = 3'd6;
  localparam logic [2:0] WAIT_HI = 3'd7;

  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_CNT-1:0] CNT_LAST =
    NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state;
  logic [NB_CNT-1:0]      cnt;
  logic [NB_DATA_OUT-1:0] result;
  logic                   busy;
  logic                   timeout;
  logic                   op_ok;
  logic [NB_DATA-1:0]     tx_lo;
  logic [NB_DATA-1:0]     tx_hi;

  assign busy    = state inside {EXEC, SEND_LO, WAIT_LO,
                                 SEND_HI, WAIT_HI};
  assign timeout = (cnt == CNT_LAST);
  assign op_ok   = op_is_valid(
    ALU_NB_OP'(i_rx_data[NB_OP-1:0]));
  assign tx_lo   = i_alu_result[NB_DATA-1:0];
  assign tx_hi   = NB_DATA'(
    result[NB_DATA_OUT-1:NB_DATA]);

  // tx_start is raised on entry to SEND_x so it is high during
  // the SEND_x cycle, two cycles after the opcode strobe.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= GET_A;
      cnt        <= '0;
      result     <= '0;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_code     <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      if (i_rx_done && busy)
        o_overrun <= 1'b1;
      case (state)
        GET_A: begin
          cnt <= '0;
          if (i_rx_done) begin
            o_data_a <= i_rx_data;
            state    <= GET_B;
          end
        end
        GET_B: begin
          if (i_rx_done) begin
            o_data_b <= i_rx_data;
            cnt      <= '0;
            state    <= GET_OP;
          end else if (timeout) begin
            o_error <= 1'b1;
            cnt     <= '0;
            state   <= GET_A;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GET_OP: begin
          if (i_rx_done) begin
            o_code <= i_rx_data[NB_OP-1:0];
            cnt    <= '0;
            if (op_ok) begin
              state <= EXEC;
            end else begin
              o_error <= 1'b1;
              state   <= GET_A;
            end
          end else if (timeout) begin
            o_error <= 1'b1;
            cnt     <= '0;
            state   <= GET_A;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          result     <= i_alu_result;
          o_tx_data  <= tx_lo;
          o_tx_start <= 1'b1;
          state      <= SEND_LO;
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (i_tx_done) begin
            o_tx_data  <= tx_hi;
            o_tx_start <= 1'b1;
            state      <= SEND_HI;
          end
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (i_tx_done)
            state <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, operand/byte width.
REQ-002 SHALL have parameter NB_OP, default 6, opcode width.
REQ-003 SHALL have parameter NB_DATA_OUT, default 9, ALU result width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, max idle cycles between bytes of one frame.
REQ-005 SHALL have port i_clock, input, 1, single clock; all flops rising-edge.
REQ-006 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_rx_data, input, NB_DATA, received byte, valid only with i_rx_done.
REQ-008 SHALL have port i_rx_done, input, 1, one-cycle strobe: byte available.
REQ-009 SHALL have port o_data_a, output, NB_DATA, registered operand A to ALU.
REQ-010 SHALL have port o_data_b, output, NB_DATA, registered operand B to ALU.
REQ-011 SHALL have port o_code, output, NB_OP, registered opcode to ALU.
REQ-012 SHALL have port i_alu_result, input, NB_DATA_OUT, combinational ALU result.
REQ-013 SHALL have port o_tx_data, output, NB_DATA, byte to transmitter.
REQ-014 SHALL have port o_tx_start, output, 1, one-cycle transmit request.
REQ-015 SHALL have port i_tx_done, input, 1, one-cycle strobe: byte sent.
REQ-016 SHALL have port o_error, output, 1, one-cycle pulse: frame aborted.
REQ-017 SHALL have port o_overrun, output, 1, sticky: byte dropped while busy.

Function
REQ-018 SHALL implement FSM states GET_A, GET_B, GET_OP, EXEC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
REQ-019 SHALL, in GET_A/GET_B, on i_rx_done latch i_rx_data into o_data_a/o_data_b and advance to GET_B/GET_OP.
REQ-020 SHALL, in GET_OP on i_rx_done, latch i_rx_data[NB_OP-1:0] into o_code; upper bits ignored.
REQ-021 SHALL treat as valid only opcodes ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
REQ-022 SHALL, on a valid opcode, go to EXEC; on an invalid opcode, pulse o_error next cycle and return to GET_A without transmitting.
REQ-023 SHALL, in EXEC (one cycle after opcode strobe), capture i_alu_result into an internal result register and go to SEND_LO.
REQ-024 SHALL, in SEND_LO, drive o_tx_data = result[7:0], assert o_tx_start exactly one cycle, go to WAIT_LO.
REQ-025 SHALL, in WAIT_LO on i_tx_done, go to SEND_HI.
REQ-026 SHALL, in SEND_HI, drive o_tx_data = {7'b0, result[8]}, assert o_tx_start one cycle, go to WAIT_HI.
REQ-027 SHALL, in WAIT_HI on i_tx_done, return to GET_A.
REQ-028 SHALL give latency opcode strobe -> first o_tx_start of exactly 2 cycles.
REQ-029 SHALL hold o_tx_data stable from SEND_x until the matching i_tx_done.
REQ-030 SHALL ignore i_tx_done outside WAIT_LO/WAIT_HI.
REQ-031 SHALL, on i_rx_done in EXEC/SEND/WAIT states, drop the byte and set o_overrun; FSM unaffected.
REQ-032 SHALL run an inter-byte counter in GET_B/GET_OP, cleared on each accepted byte and on entering GET_B.
REQ-033 SHALL, when counter reaches TIMEOUT_CYCLES-1 without i_rx_done, pulse o_error and return to GET_A; i_rx_done in that same cycle wins (byte accepted, no error).
REQ-034 SHALL not time out in GET_A or in WAIT states.
REQ-035 SHALL keep o_data_a/o_data_b/o_code unchanged on abort until overwritten.

Reset
REQ-036 SHALL, on i_reset low, asynchronously force state GET_A, counter 0, result 0, and all outputs (o_data_a, o_data_b, o_code, o_tx_data, o_tx_start, o_error, o_overrun) to 0.
REQ-037 SHALL, on reset mid-frame or mid-transmit, discard the frame; no o_tx_start after release until a new frame completes.
REQ-038 SHALL only clear o_overrun by reset.

Structure
REQ-039 SHALL take opcode constants and NB_* widths from a shared alu definitions package also used by the ALU.
REQ-040 SHALL contain no sub-modules; the ALU is instantiated beside it at top level, not inside.

Verification
REQ-041 SHALL test bytes 0x05,0x03,0x20 -> o_tx_data 0x08 then 0x00, two o_tx_start pulses.
REQ-042 SHALL test 0xFF,0x01,0x20 -> bytes 0x00 then 0x01; 0x03,0x05,0x22 -> 0xFE then 0x01.
REQ-043 SHALL test 0x0F,0x01,0x3F (invalid) -> one o_error pulse, no o_tx_start, next frame processed normally.
REQ-044 SHALL test 0x0F then silence TIMEOUT_CYCLES cycles -> o_error pulse, state GET_A; byte on the final cycle -> accepted, no error.
REQ-045 SHALL test an extra i_rx_done during WAIT_LO -> o_overrun=1, transmission completes unchanged.
REQ-046 SHALL test i_reset low during WAIT_HI -> all outputs 0 immediately, no further o_tx_start.
